// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared constants and types for the unified memory port arbiter
package mem_port_arbiter_pkg;

  localparam int DEF_RAM_AW      = 13;
  localparam int DEF_MAX_DSTREAK = 4;

  // Which port owns the RAM read that is in flight this cycle
  typedef enum logic [1:0] {
    TAG_NONE = 2'd0,
    TAG_IF   = 2'd1,
    TAG_D    = 2'd2
  } tag_e;

endpackage

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - single-port RAM shared between fetch and load/store with data priority
import mem_port_arbiter_pkg::*;

module mem_port_arbiter #(
  parameter int RAM_AW      = DEF_RAM_AW,
  parameter int MAX_DSTREAK = DEF_MAX_DSTREAK
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [31:0]       if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [31:0]       if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [3:0]        d_wmask,
  input  logic [31:0]       d_addr,
  input  logic [31:0]       d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [31:0]       d_rdata,
  output logic              d_err,
  output logic              ram_en,
  output logic              ram_we,
  output logic [3:0]        ram_wmask,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata
);

  localparam int              SW         = $clog2(MAX_DSTREAK + 1);
  localparam logic [SW-1:0]   STREAK_MAX = SW'(MAX_DSTREAK);

  logic [SW-1:0] streak_q;
  tag_e          tag_q;
  tag_e          tag_d;
  logic [31:0]   if_rdata_q;
  logic [31:0]   d_rdata_q;
  logic          d_err_q;
  logic          d_oor;

  // Address bits outside the RAM word index are intentionally ignored for fetch
  logic unused_addr_bits;
  assign unused_addr_bits = ^{if_addr[31:RAM_AW+2], if_addr[1:0], d_addr[1:0]};

  assign d_oor = |d_addr[31:RAM_AW+2];

  // Grant: data wins unless fetch has already waited through MAX_DSTREAK data grants
  always_comb begin
    if_gnt = 1'b0;
    d_gnt  = 1'b0;
    if (d_req && (!if_req || (streak_q < STREAK_MAX))) begin
      d_gnt = 1'b1;
    end else if (if_req) begin
      if_gnt = 1'b1;
    end
  end

  // RAM drive from the granted port; out-of-range data accesses never touch the RAM
  always_comb begin
    ram_en    = if_gnt | (d_gnt & ~d_oor);
    ram_we    = d_gnt & d_we & ~d_oor;
    ram_wmask = d_we ? d_wmask : 4'b0000;
    ram_addr  = d_gnt ? d_addr[RAM_AW+1:2] : if_addr[RAM_AW+1:2];
    ram_wdata = d_wdata;
  end

  // Tag for the read issued this cycle; writes and rejected accesses return nothing
  always_comb begin
    tag_d = TAG_NONE;
    if (if_gnt) begin
      tag_d = TAG_IF;
    end else if (d_gnt && !d_we && !d_oor) begin
      tag_d = TAG_D;
    end
  end

  // Count data grants taken while fetch is waiting; any fetch grant or idle fetch clears it
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      streak_q <= '0;
    end else if (if_gnt || !if_req) begin
      streak_q <= '0;
    end else if (d_gnt && (streak_q != STREAK_MAX)) begin
      streak_q <= streak_q + SW'(1);
    end
  end

  // Pending read tag and out-of-range flag, both live for exactly one cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tag_q   <= TAG_NONE;
      d_err_q <= 1'b0;
    end else begin
      tag_q   <= tag_d;
      d_err_q <= d_gnt & d_oor;
    end
  end

  // Keep the last returned word per port so rdata stays stable between returns
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      if (tag_q == TAG_IF) if_rdata_q <= ram_rdata;
      if (tag_q == TAG_D)  d_rdata_q  <= ram_rdata;
    end
  end

  assign if_rvalid = (tag_q == TAG_IF);
  assign d_rvalid  = (tag_q == TAG_D);
  assign if_rdata  = if_rvalid ? ram_rdata : if_rdata_q;
  assign d_rdata   = d_rvalid  ? ram_rdata : d_rdata_q;
  assign d_err     = d_err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - randomized self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

  localparam int RAM_AW = 13;
  localparam int MAXD   = 4;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              if_req = 1'b0;
  logic [31:0]       if_addr = '0;
  logic              if_gnt;
  logic              if_rvalid;
  logic [31:0]       if_rdata;
  logic              d_req = 1'b0;
  logic              d_we = 1'b0;
  logic [3:0]        d_wmask = '0;
  logic [31:0]       d_addr = '0;
  logic [31:0]       d_wdata = '0;
  logic              d_gnt;
  logic              d_rvalid;
  logic [31:0]       d_rdata;
  logic              d_err;
  logic              ram_en;
  logic              ram_we;
  logic [3:0]        ram_wmask;
  logic [RAM_AW-1:0] ram_addr;
  logic [31:0]       ram_wdata;
  logic [31:0]       ram_rdata = '0;

  mem_port_arbiter #(.RAM_AW(RAM_AW), .MAX_DSTREAK(MAXD)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_wmask(d_wmask), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
    .ram_en(ram_en), .ram_we(ram_we), .ram_wmask(ram_wmask), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  // RAM with 1-cycle read latency plus a preload port used while the DUT is in reset
  logic [31:0]       mem [0:8191];
  logic              pl_en = 1'b0;
  logic [12:0]       pl_addr = '0;
  logic [31:0]       pl_data = '0;
  always @(posedge clk) begin
    if (pl_en) begin
      mem[pl_addr] <= pl_data;
    end else if (ram_en) begin
      if (ram_we) begin
        for (int b = 0; b < 4; b++)
          if (ram_wmask[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
      end else begin
        ram_rdata <= mem[ram_addr];
      end
    end
  end

  // Reference model state
  logic [31:0] ref_mem [0:8191];
  int          streak = 0;
  bit          e_iv = 0, e_dv = 0, e_err = 0;
  logic [31:0] e_id = '0, e_dd = '0, last_i = '0, last_d = '0;
  int          total = 0, bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One clock cycle: check last cycle's returns, drive requests, check grant and RAM drive
  task automatic step(input bit ifr, input logic [31:0] ia, input bit dr, input bit dwe,
                      input logic [3:0] dm, input logic [31:0] da, input logic [31:0] dw,
                      output bit gi, output bit gd);
    bit ei, ed, oor;
    int wi, wd;
    @(negedge clk);
    check("if_rvalid", {31'b0, if_rvalid}, {31'b0, e_iv});
    if (e_iv) last_i = e_id;
    check("if_rdata", if_rdata, last_i);
    check("d_rvalid", {31'b0, d_rvalid}, {31'b0, e_dv});
    if (e_dv) last_d = e_dd;
    check("d_rdata", d_rdata, last_d);
    check("d_err", {31'b0, d_err}, {31'b0, e_err});

    if_req = ifr; if_addr = ia;
    d_req = dr; d_we = dwe; d_wmask = dm; d_addr = da; d_wdata = dw;
    #1;
    oor = (da >> (RAM_AW + 2)) != 0;
    ed  = dr && (!ifr || streak < MAXD);
    ei  = ifr && !ed;
    wi  = int'((ia >> 2) & 32'h1FFF);
    wd  = int'((da >> 2) & 32'h1FFF);
    check("if_gnt", {31'b0, if_gnt}, {31'b0, ei});
    check("d_gnt", {31'b0, d_gnt}, {31'b0, ed});
    check("ram_en", {31'b0, ram_en}, {31'b0, (ei || (ed && !oor))});
    check("ram_we", {31'b0, ram_we}, {31'b0, (ed && dwe && !oor)});
    if (ei) check("ram_addr_if", {19'b0, ram_addr}, 32'(wi));
    if (ed && !oor) check("ram_addr_d", {19'b0, ram_addr}, 32'(wd));
    if (ed && dwe && !oor) begin
      check("ram_wmask", {28'b0, ram_wmask}, {28'b0, dm});
      check("ram_wdata", ram_wdata, dw);
    end

    e_iv = ei;
    if (ei) e_id = ref_mem[wi];
    e_dv = ed && !dwe && !oor;
    if (e_dv) e_dd = ref_mem[wd];
    e_err = ed && oor;
    if (ed && dwe && !oor)
      for (int b = 0; b < 4; b++)
        if (dm[b]) ref_mem[wd][8*b +: 8] = dw[8*b +: 8];
    if (!ifr || ei) streak = 0;
    else if (ed && streak < MAXD) streak++;
    gi = ei;
    gd = ed;
  endtask

  task automatic idle();
    bit gi, gd;
    step(0, '0, 0, 0, '0, '0, '0, gi, gd);
  endtask

  initial begin
    bit gi, gd, ip, dp, dwe;
    logic [31:0] ia, da, dw, v;
    logic [3:0] dm;
    logic [7:0] order;

    // Reset held while the RAM is preloaded; outputs must stay idle throughout
    for (int i = 0; i < 128; i++) begin
      @(negedge clk);
      if (i < 3) v = 32'h11 * 32'(i + 1);
      else if (i == 16) v = 32'h0;
      else v = $urandom;
      pl_en = 1'b1; pl_addr = 13'(i); pl_data = v; ref_mem[i] = v;
      if (i % 32 == 5) begin
        check("rst_if_rvalid", {31'b0, if_rvalid}, 32'h0);
        check("rst_d_rvalid", {31'b0, d_rvalid}, 32'h0);
        check("rst_d_err", {31'b0, d_err}, 32'h0);
        check("rst_if_rdata", if_rdata, 32'h0);
        check("rst_d_rdata", d_rdata, 32'h0);
        check("rst_ram_en", {31'b0, ram_en}, 32'h0);
      end
    end
    @(negedge clk);
    pl_en = 1'b0;
    reset = 1'b1;
    repeat (3) idle();

    // Back-to-back fetches
    step(1, 32'h0, 0, 0, '0, '0, '0, gi, gd);
    step(1, 32'h4, 0, 0, '0, '0, '0, gi, gd);
    step(1, 32'h8, 0, 0, '0, '0, '0, gi, gd);
    idle();
    check("t2_last_if", if_rdata, 32'h33);
    idle();

    // Simultaneous fetch and data read: data first
    step(1, 32'hC, 1, 0, '0, 32'h100, '0, gi, gd);
    check("t3_first_d", {31'b0, gd}, 32'h1);
    step(1, 32'hC, 0, 0, '0, '0, '0, gi, gd);
    idle();
    idle();

    // Starvation guard: fetch gets in after MAX data grants
    order = '0;
    for (int i = 0; i < 8; i++) begin
      step(1, 32'h20, 1, 0, '0, 32'h24, '0, gi, gd);
      order[i] = if_gnt;
    end
    check("t4_order", {24'b0, order}, 32'h10);
    idle();
    idle();

    // Masked write then read back the merged word
    step(0, '0, 1, 1, 4'b0101, 32'h40, 32'hAABBCCDD, gi, gd);
    step(0, '0, 1, 0, '0, 32'h40, '0, gi, gd);
    idle();
    check("t5_rdata", d_rdata, 32'h00BB00DD);
    idle();
    check("t5_single_pulse", {31'b0, d_rvalid}, 32'h0);

    // Reset in the middle of a read drops the return
    step(0, '0, 1, 0, '0, 32'h44, '0, gi, gd);
    if_req = 0; d_req = 0;
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("t6_rst_rvalid", {31'b0, d_rvalid}, 32'h0);
    reset = 1'b1;
    e_iv = 0; e_dv = 0; e_err = 0; streak = 0; last_i = '0; last_d = '0;
    idle();
    idle();

    // Out-of-range data access
    step(0, '0, 1, 0, '0, 32'h8000_0000, '0, gi, gd);
    idle();
    idle();

    // Randomized traffic with held requests
    ip = 0; dp = 0; ia = '0; da = '0; dw = '0; dwe = 0; dm = '0;
    for (int c = 0; c < 500; c++) begin
      if (!ip) begin
        ip = ($urandom % 3) != 0;
        ia = ($urandom & 32'hFFFF_0000) | (32'($urandom_range(0, 127)) << 2);
      end
      if (!dp) begin
        dp  = ($urandom % 2) != 0;
        dwe = ($urandom % 2) != 0;
        dm  = 4'($urandom);
        dw  = $urandom;
        if ($urandom % 10 == 0) da = 32'h0000_8000 | ($urandom & 32'hFFFF_FFFC);
        else da = 32'($urandom_range(0, 127)) << 2;
      end
      step(ip, ia, dp, dwe, dm, da, dw, gi, gd);
      if (gi) ip = 0;
      if (gd) dp = 0;
    end
    idle();
    idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
